// File: rtl/pool_pkg.sv
// Shared definitions for the parametrised pooling engine.
//   - window size encodings (SZ_*), pooling mode encodings (POOL_*)
//   - FSM state enum used by the top level
//   - k_of(size):     window edge length K (1, 2 or 4)
//   - shift_of(size): log2(K*K), the right shift that turns a window sum
//                     into an average
package pool_pkg;

  localparam logic [1:0] SZ_1X1  = 2'd0;
  localparam logic [1:0] SZ_2X2  = 2'd1;
  localparam logic [1:0] SZ_4X4  = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  function automatic int k_of(input logic [1:0] size);
    case (size)
      SZ_2X2:  return 2;
      SZ_4X4:  return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] shift_of(input logic [1:0] size);
    case (size)
      SZ_2X2:  return 3'd2;
      SZ_4X4:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pool_engine_param_if.sv
// Job/data bus of the pooling engine.
//   master: start, size, pool_sel, n_win, en, d_in  (driven by the producer)
//   slave:  o_pool, o_valid, busy, done, err        (driven by the engine)
interface pool_engine_param_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int CNT_W  = 8
);

  logic                    start;
  logic [1:0]              size;
  logic                    pool_sel;
  logic [CNT_W-1:0]        n_win;
  logic                    en;
  logic [LANES*DATA_W-1:0] d_in;
  logic [LANES*DATA_W-1:0] o_pool;
  logic                    o_valid;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, size, pool_sel, n_win, en, d_in,
    input  o_pool, o_valid, busy, done, err
  );

  modport slave (
    input  start, size, pool_sel, n_win, en, d_in,
    output o_pool, o_valid, busy, done, err
  );

endinterface

// File: rtl/pool_lane_acc.sv
// One output lane of the pooling engine.
// Reduces up to four horizontally adjacent samples of the current row
// (only the first K are used), then folds that row value into a running
// sum (average mode) or running signed max (max mode). The first row of a
// window reloads the accumulator so consecutive windows need no bubble.
// result is the finalised window value computed from the accumulator
// including the current row; the top registers it at window end.
//   clk, srst  clock, synchronous active-high reset
//   accept     current row is consumed
//   first_row  current row is row 0 of a window (reload)
//   pool_sel   POOL_AVG / POOL_MAX
//   size       window size code (selects K and the average shift)
//   samples    4 samples, sample m = samples[m*DATA_W +: DATA_W]
//   result     finalised window value (DATA_W)
module pool_lane_acc
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                accept,
  input  logic                first_row,
  input  logic                pool_sel,
  input  logic [1:0]          size,
  input  logic [4*DATA_W-1:0] samples,
  output logic [DATA_W-1:0]   result
);

  logic signed [ACC_W-1:0] ext [4];
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] row_val;
  logic signed [ACC_W-1:0] rnd;
  logic [2:0]              sh;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ext
    assign ext[gi] = {{(ACC_W-DATA_W){samples[gi*DATA_W+DATA_W-1]}},
                      samples[gi*DATA_W +: DATA_W]};
  end

  // Horizontal reduce of the K samples belonging to this lane.
  always_comb begin
    row_val = ext[0];
    for (int m = 1; m < 4; m++) begin
      if (m < k_of(size)) begin
        if (pool_sel == POOL_MAX) begin
          if (ext[m] > row_val) row_val = ext[m];
        end else begin
          row_val = row_val + ext[m];
        end
      end
    end
  end

  // Vertical fold across rows; ties in max mode keep the held value.
  always_comb begin
    acc_next = acc_reg;
    if (first_row) begin
      acc_next = row_val;
    end else if (pool_sel == POOL_MAX) begin
      if (row_val > acc_reg) acc_next = row_val;
    end else begin
      acc_next = acc_reg + row_val;
    end
  end

  // Round-half-up average: (sum + 2^(s-1)) >>> s. With 4 guard bits the
  // largest 4x4 sum plus rounding term still fits ACC_W, and the shifted
  // result always fits DATA_W, so plain truncation is exact.
  always_comb begin
    sh     = (pool_sel == POOL_MAX) ? 3'd0 : shift_of(size);
    rnd    = (sh == 3'd0) ? '0 : (ACC_W'(1) << (sh - 3'd1));
    result = DATA_W'((acc_next + rnd) >>> sh);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/pool_engine_param.sv
// Parametrised KxK average/max pooling engine (K = 1, 2, 4).
// A job of n_win vertical windows is launched by a start pulse in IDLE;
// each window consumes K accepted rows (en=1) and emits one pooled row.
//   clk      clock, rising edge
//   rst_fsm  synchronous active-high reset, aborts a running job
//   bus      pool_engine_param_if.slave:
//              start/size/pool_sel/n_win  job request (latched at start)
//              en/d_in                    input row stream
//              o_pool/o_valid             pooled row, 1-cycle valid pulse
//              busy                       high while accumulating
//              done                       1-cycle pulse at job end
//              err                        1-cycle pulse on reserved size
module pool_engine_param
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int CNT_W  = 8
) (
  input logic                 clk,
  input logic                 rst_fsm,
  pool_engine_param_if.slave  bus
);

  state_t                  state_reg;
  logic [1:0]              size_lat;
  logic                    sel_lat;
  logic [CNT_W-1:0]        nwin_lat;
  logic [1:0]              row_cnt_reg;
  logic [CNT_W-1:0]        win_cnt_reg;
  logic [LANES*DATA_W-1:0] o_pool_reg;
  logic                    o_valid_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    err_reg;

  logic                    accept;
  logic                    first_row;
  logic                    last_row;
  logic                    last_win;
  logic [LANES*DATA_W-1:0] pool_next;

  assign accept    = (state_reg == ST_ACCUM) && bus.en;
  assign first_row = (row_cnt_reg == 2'd0);
  assign last_row  = (int'(row_cnt_reg) == k_of(size_lat) - 1);
  assign last_win  = (win_cnt_reg == nwin_lat - CNT_W'(1));

  // Output lane gi sees input lanes gi*K .. gi*K+K-1. The three candidate
  // groupings are wired statically and muxed by the latched size, so
  // out-of-range source lanes simply become zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [4*DATA_W-1:0] grp1;
    logic [4*DATA_W-1:0] grp2;
    logic [4*DATA_W-1:0] grp4;
    logic [4*DATA_W-1:0] grp;
    logic [DATA_W-1:0]   res;

    for (genvar gm = 0; gm < 4; gm++) begin : g_smp
      if (gm == 0) begin : g_k1
        assign grp1[gm*DATA_W +: DATA_W] = bus.d_in[gi*DATA_W +: DATA_W];
      end else begin : g_k1z
        assign grp1[gm*DATA_W +: DATA_W] = '0;
      end
      if (gm < 2 && 2*gi+gm < LANES) begin : g_k2
        assign grp2[gm*DATA_W +: DATA_W] = bus.d_in[(2*gi+gm)*DATA_W +: DATA_W];
      end else begin : g_k2z
        assign grp2[gm*DATA_W +: DATA_W] = '0;
      end
      if (4*gi+gm < LANES) begin : g_k4
        assign grp4[gm*DATA_W +: DATA_W] = bus.d_in[(4*gi+gm)*DATA_W +: DATA_W];
      end else begin : g_k4z
        assign grp4[gm*DATA_W +: DATA_W] = '0;
      end
    end

    always_comb begin
      case (size_lat)
        SZ_2X2:  grp = grp2;
        SZ_4X4:  grp = grp4;
        default: grp = grp1;
      endcase
    end

    pool_lane_acc #(
      .DATA_W (DATA_W)
    ) u_acc (
      .clk       (clk),
      .srst      (rst_fsm),
      .accept    (accept),
      .first_row (first_row),
      .pool_sel  (sel_lat),
      .size      (size_lat),
      .samples   (grp),
      .result    (res)
    );

    // Only LANES/K output lanes carry data; the rest are forced to zero.
    assign pool_next[gi*DATA_W +: DATA_W] =
      (gi * k_of(size_lat) < LANES) ? res : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_fsm) begin
      state_reg   <= ST_IDLE;
      size_lat    <= SZ_1X1;
      sel_lat     <= POOL_AVG;
      nwin_lat    <= '0;
      row_cnt_reg <= '0;
      win_cnt_reg <= '0;
      o_pool_reg  <= '0;
      o_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      o_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            // Reserved size is rejected before n_win is considered.
            if (bus.size == SZ_RSVD) begin
              err_reg <= 1'b1;
            end else begin
              size_lat    <= bus.size;
              sel_lat     <= bus.pool_sel;
              nwin_lat    <= bus.n_win;
              row_cnt_reg <= '0;
              win_cnt_reg <= '0;
              if (bus.n_win == '0) begin
                state_reg <= ST_FIN;
              end else begin
                state_reg <= ST_ACCUM;
                busy_reg  <= 1'b1;
              end
            end
          end
        end
        ST_ACCUM: begin
          if (bus.en) begin
            if (last_row) begin
              row_cnt_reg <= '0;
              o_pool_reg  <= pool_next;
              o_valid_reg <= 1'b1;
              if (last_win) begin
                state_reg <= ST_FIN;
                busy_reg  <= 1'b0;
              end else begin
                win_cnt_reg <= win_cnt_reg + CNT_W'(1);
              end
            end else begin
              row_cnt_reg <= row_cnt_reg + 2'd1;
            end
          end
        end
        ST_FIN: begin
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_pool  = o_pool_reg;
  assign bus.o_valid = o_valid_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_pool_engine_param.sv
// Bench for pool_engine_param: randomized jobs plus directed cases, checked
// every cycle against an expected timeline built from window arithmetic.
module tb_pool_engine_param;
  import pool_pkg::*;

  localparam int DATA_W = 16;
  localparam int LANES  = 8;
  localparam int CNT_W  = 8;
  localparam int VW     = LANES * DATA_W;
  localparam int MAXC   = 8192;

  logic clk = 1'b0;
  logic rst_fsm = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_on = 1'b0;

  // Expected timeline, indexed by cycle number.
  bit            exp_valid [MAXC];
  bit            exp_done  [MAXC];
  bit            exp_err   [MAXC];
  bit            exp_busy  [MAXC];
  bit            exp_clr   [MAXC];
  logic [VW-1:0] exp_pool  [MAXC];
  logic [VW-1:0] hold = '0;

  int win_rows [4][LANES];
  int dir_rows [16][LANES];
  int row_tmp  [LANES];

  pool_engine_param_if #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();

  pool_engine_param #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_fsm (rst_fsm),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Window result from first principles: sum/max of the KxK block per
  // output lane, average rounded half-up via floor((sum + N/2) / N).
  function automatic logic [VW-1:0] model_window(input int k, input bit is_max);
    logic [VW-1:0] v;
    int acc;
    int x;
    int s;
    v = '0;
    s = (k == 1) ? 0 : (k == 2) ? 2 : 4;
    for (int j = 0; j < LANES / k; j++) begin
      acc = is_max ? win_rows[0][j*k] : 0;
      for (int r = 0; r < k; r++) begin
        for (int m = 0; m < k; m++) begin
          x = win_rows[r][j*k+m];
          if (is_max) acc = (x > acc) ? x : acc;
          else        acc = acc + x;
        end
      end
      if (!is_max && s > 0) acc = (acc + (1 << (s - 1))) >>> s;
      v[j*DATA_W +: DATA_W] = acc[DATA_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_row();
    logic [VW-1:0] v;
    int x;
    for (int i = 0; i < LANES; i++) begin
      x = row_tmp[i];
      v[i*DATA_W +: DATA_W] = x[DATA_W-1:0];
    end
    return v;
  endfunction

  function automatic int rand_sample();
    logic signed [DATA_W-1:0] t;
    case ($urandom_range(0, 5))
      0:       t = {1'b1, {(DATA_W-1){1'b0}}};
      1:       t = {1'b0, {(DATA_W-1){1'b1}}};
      default: t = DATA_W'($urandom);
    endcase
    return int'(t);
  endfunction

  task automatic junk_inputs();
    bus.size     = 2'($urandom);
    bus.pool_sel = 1'($urandom);
    bus.n_win    = CNT_W'($urandom_range(0, 3));
    for (int i = 0; i < LANES; i++) row_tmp[i] = rand_sample();
    bus.d_in = pack_row();
  endtask

  // Drives one job and records what the outputs must do. abort_at >= 0
  // asserts rst_fsm instead of feeding row number abort_at.
  task automatic run_job(input logic [1:0] sz, input bit sel, input int nw,
                         input int stall_pct, input bit directed, input int abort_at);
    int k;
    int n0;
    int idx;
    k = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 1;
    junk_inputs();
    bus.start = 1'b1; bus.size = sz; bus.pool_sel = sel; bus.n_win = CNT_W'(nw);
    bus.en = 1'($urandom);
    n0 = cyc;
    if (sz == 2'd3)   exp_err[n0+1]  = 1'b1;
    else if (nw == 0) exp_done[n0+2] = 1'b1;
    step();
    if (sz == 2'd3 || nw == 0) begin
      // For the empty job this start lands in FIN and must be ignored.
      bus.start = (sz != 2'd3); bus.size = 2'd3; bus.en = 1'b1;
      step();
      bus.start = 1'b0; bus.en = 1'b0;
      return;
    end
    idx = 0;
    for (int w = 0; w < nw; w++) begin
      for (int r = 0; r < k; r++) begin
        while ($urandom_range(0, 99) < stall_pct) begin
          junk_inputs();
          bus.en = 1'b0;
          bus.start = ($urandom_range(0, 3) == 0);
          exp_busy[cyc] = 1'b1;
          step();
        end
        if (idx == abort_at) begin
          rst_fsm = 1'b1;
          bus.start = 1'b1; bus.size = 2'd1; bus.n_win = 1; bus.en = 1'b1;
          exp_busy[cyc] = 1'b1;
          for (int c = cyc + 1; c < cyc + 8; c++) begin
            exp_valid[c] = 1'b0; exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_busy[c] = 1'b0;
          end
          exp_clr[cyc+1] = 1'b1;
          step();
          rst_fsm = 1'b0; bus.start = 1'b0; bus.en = 1'b0;
          step();
          return;
        end
        junk_inputs();
        for (int i = 0; i < LANES; i++) begin
          row_tmp[i] = directed ? dir_rows[idx][i] : rand_sample();
          win_rows[r][i] = row_tmp[i];
        end
        bus.d_in = pack_row();
        bus.en = 1'b1;
        bus.start = ($urandom_range(0, 3) == 0);
        exp_busy[cyc] = 1'b1;
        if (r == k - 1) begin
          exp_valid[cyc+1] = 1'b1;
          exp_pool[cyc+1]  = model_window(k, sel);
          if (w == nw - 1) exp_done[cyc+2] = 1'b1;
        end
        idx++;
        step();
      end
    end
    // FIN cycle: a start here must be ignored (no err, no relaunch).
    bus.en = 1'b1; bus.start = 1'b1; bus.size = 2'd3; bus.n_win = 1;
    step();
    bus.start = 1'b0; bus.en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      if (exp_clr[cyc])   hold = '0;
      if (exp_valid[cyc]) hold = exp_pool[cyc];
      check1("o_valid", bus.o_valid, exp_valid[cyc]);
      check1("done",    bus.done,    exp_done[cyc]);
      check1("err",     bus.err,     exp_err[cyc]);
      check1("busy",    bus.busy,    exp_busy[cyc]);
      checkv("o_pool",  bus.o_pool,  hold);
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [VW-1:0] lit;
    bus.start = 1'b0; bus.size = 2'd0; bus.pool_sel = 1'b0; bus.n_win = '0;
    bus.en = 1'b0; bus.d_in = '0;
    rst_fsm = 1'b1;
    step();
    chk_on = 1'b1;
    // Start during reset must not launch anything.
    bus.en = 1'b1; bus.start = 1'b1; bus.size = 2'd1; bus.n_win = 1;
    step();
    step();
    rst_fsm = 1'b0; bus.start = 1'b0; bus.en = 1'b0;
    step();

    // 1) 2x2 average, rows 1..8 and 9..16.
    for (int i = 0; i < LANES; i++) begin
      dir_rows[0][i] = i + 1;
      dir_rows[1][i] = i + 9;
      win_rows[0][i] = dir_rows[0][i];
      win_rows[1][i] = dir_rows[1][i];
    end
    lit = 128'h0000_0000_0000_0000_000C_000A_0008_0006;
    checkv("model_pin_avg2x2", model_window(2, 1'b0), lit);
    run_job(2'd1, 1'b0, 1, 0, 1'b1, -1);
    checkv("t1_o_pool_literal", bus.o_pool, lit);

    // 2) 2x2 max over extreme negative data, two windows.
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < LANES; i++) dir_rows[r][i] = -32768;
    dir_rows[1][3] = -7;
    dir_rows[2][0] = 32767;
    dir_rows[2][6] = -2;
    dir_rows[3][5] = -1;
    run_job(2'd1, 1'b1, 2, 30, 1'b1, -1);
    lit = 128'h0000_0000_0000_0000_FFFE_FFFF_8000_7FFF;
    checkv("t2_o_pool_literal", bus.o_pool, lit);

    // 3) 4x4 average of full-scale positive data with stalls.
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < LANES; i++) dir_rows[r][i] = 32767;
    run_job(2'd2, 1'b0, 1, 50, 1'b1, -1);
    lit = 128'h0000_0000_0000_0000_0000_0000_7FFF_7FFF;
    checkv("t3_o_pool_literal", bus.o_pool, lit);

    // 4) 1x1 pass-through, three rows.
    run_job(2'd0, 1'($urandom), 3, 30, 1'b0, -1);

    // 5) reserved size, empty job, reserved size with empty job.
    run_job(2'd3, 1'b0, 2, 0, 1'b0, -1);
    run_job(2'd1, 1'b0, 0, 0, 1'b0, -1);
    run_job(2'd3, 1'b1, 0, 0, 1'b0, -1);

    // 6) reset in the middle of the second 4x4 window, then a fresh job.
    run_job(2'd2, 1'b0, 2, 20, 1'b0, 5);
    run_job(2'd1, 1'b1, 2, 20, 1'b0, -1);

    // Randomized jobs.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_job(sz, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 40), 1'b0,
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1);
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
